// File: rtl/inst_rom_if.sv
// Fetch-side bus between the fetch stage (master) and the instruction ROM (slave).
interface inst_rom_if;
    logic        romCe;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        instValid;
    logic [31:0] instPc;
    logic        fetchErr;

    modport master (output romCe, pc, input inst, instValid, instPc, fetchErr);
    modport slave  (input romCe, pc, output inst, instValid, instPc, fetchErr);
endinterface

// File: rtl/inst_rom.sv
// Instruction ROM: registered 1-cycle fetch plus a byte-serial big-endian program loader.
module inst_rom #(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    inst_rom_if.slave         fetch,
    input  logic              ldStart,
    input  logic              ldByteValid,
    input  logic [7:0]        ldByte,
    input  logic              ldEnd,
    output logic              ldBusy,
    output logic [ADDR_W:0]   ldCount,
    output logic              ldOvf
);
    localparam int             DEPTH      = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic {RUN, LOAD} state_t;

    state_t            r_state, w_nextState;
    logic [1:0]        r_byteCnt, w_byteCnt;
    logic [23:0]       r_buf, w_buf;
    logic [ADDR_W:0]   r_ldCount, w_ldCount;
    logic              r_ldOvf, w_ldOvf;
    logic              r_ldBusy;
    logic              w_memWe;
    logic [ADDR_W-1:0] w_memAddr;
    logic [31:0]       w_memData;
    logic [31:0]       r_mem [0:DEPTH-1];

    logic [31:0]       r_inst;
    logic              r_instValid;
    logic [31:0]       r_instPc;
    logic              r_fetchErr;
    logic              w_fetchOk;
    logic [ADDR_W-1:0] w_fetchIdx;

    // The byte is consumed before end processing so a final byte arriving with ldEnd lands in the partial word.
    always_comb begin
        w_nextState = r_state;
        w_byteCnt   = r_byteCnt;
        w_buf       = r_buf;
        w_ldCount   = r_ldCount;
        w_ldOvf     = r_ldOvf;
        w_memWe     = 1'b0;
        w_memAddr   = r_ldCount[ADDR_W-1:0];
        w_memData   = 32'h0;
        case (r_state)
            RUN: begin
                if (ldStart) begin
                    w_nextState = LOAD;
                    w_byteCnt   = 2'd0;
                    w_buf       = 24'h0;
                    w_ldCount   = '0;
                    w_ldOvf     = 1'b0;
                end
            end
            LOAD: begin
                if (ldStart) begin
                    w_byteCnt = 2'd0;
                    w_buf     = 24'h0;
                    w_ldCount = '0;
                    w_ldOvf   = 1'b0;
                end else begin
                    if (ldByteValid) begin
                        if (r_ldCount == FULL_COUNT) begin
                            w_ldOvf = 1'b1;
                        end else if (r_byteCnt == 2'd3) begin
                            w_memWe   = 1'b1;
                            w_memData = {r_buf, ldByte};
                            w_ldCount = r_ldCount + 1'b1;
                            w_byteCnt = 2'd0;
                            w_buf     = 24'h0;
                        end else begin
                            w_buf     = {r_buf[15:0], ldByte};
                            w_byteCnt = r_byteCnt + 2'd1;
                        end
                    end
                    if (ldEnd) begin
                        w_nextState = RUN;
                        if (w_byteCnt != 2'd0 && w_ldCount != FULL_COUNT) begin
                            w_memWe = 1'b1;
                            case (w_byteCnt)
                                2'd1:    w_memData = {w_buf[7:0], 24'h0};
                                2'd2:    w_memData = {w_buf[15:0], 16'h0};
                                default: w_memData = {w_buf, 8'h0};
                            endcase
                            w_ldCount = w_ldCount + 1'b1;
                        end
                        w_byteCnt = 2'd0;
                        w_buf     = 24'h0;
                    end
                end
            end
            default: w_nextState = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RUN;
            r_byteCnt <= 2'd0;
            r_buf     <= 24'h0;
            r_ldCount <= '0;
            r_ldOvf   <= 1'b0;
            r_ldBusy  <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_byteCnt <= w_byteCnt;
            r_buf     <= w_buf;
            r_ldCount <= w_ldCount;
            r_ldOvf   <= w_ldOvf;
            r_ldBusy  <= (w_nextState == LOAD);
        end
    end

    // Array is deliberately not reset; a reset mid-load only suppresses the pending write.
    always_ff @(posedge clk) begin
        if (w_memWe && !rst) begin
            r_mem[w_memAddr] <= w_memData;
        end
    end

    assign w_fetchOk  = (fetch.pc[1:0] == 2'b00) && (fetch.pc[31:ADDR_W+2] == '0);
    assign w_fetchIdx = fetch.pc[ADDR_W+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inst      <= NOP_INST;
            r_instValid <= 1'b0;
            r_instPc    <= 32'h0;
            r_fetchErr  <= 1'b0;
        end else if (r_state == RUN && fetch.romCe) begin
            r_instValid <= 1'b1;
            r_instPc    <= fetch.pc;
            if (w_fetchOk) begin
                r_inst     <= r_mem[w_fetchIdx];
                r_fetchErr <= 1'b0;
            end else begin
                r_inst     <= NOP_INST;
                r_fetchErr <= 1'b1;
            end
        end else begin
            r_instValid <= 1'b0;
            r_inst      <= NOP_INST;
            r_fetchErr  <= 1'b0;
        end
    end

    assign fetch.inst      = r_inst;
    assign fetch.instValid = r_instValid;
    assign fetch.instPc    = r_instPc;
    assign fetch.fetchErr  = r_fetchErr;
    assign ldBusy          = r_ldBusy;
    assign ldCount         = r_ldCount;
    assign ldOvf           = r_ldOvf;
endmodule
